// File: rtl/traffic_ctrl_nway.sv
// traffic_ctrl_nway: round-robin N-way intersection controller.
// Sequences GREEN -> YELLOW -> CLEAR across the approaches, skipping those
// without demand, inserts a pedestrian WALK phase on request and offers a
// flashing night mode. All timing is counted in blink ticks.
module traffic_ctrl_nway #(
    parameter int C_N_WAYS     = 4,
    parameter int C_CNT_W      = 8,
    parameter int C_INT_GREEN  = 40,
    parameter int C_INT_YELLOW = 10,
    parameter int C_INT_CLEAR  = 5,
    parameter int C_INT_WALK   = 40
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          blink,
    input  logic                          inMode,
    input  logic [C_N_WAYS-1:0]           inTraffic,
    input  logic [C_N_WAYS-1:0]           inPedestrian,
    output logic [2*C_N_WAYS-1:0]         outLight,
    output logic [C_N_WAYS-1:0]           outPedLatch,
    output logic [$clog2(C_N_WAYS)-1:0]   outActive
);

    localparam int AW = $clog2(C_N_WAYS);

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_GREEN  = 3'd1;
    localparam logic [2:0] S_YELLOW = 3'd2;
    localparam logic [2:0] S_WALK   = 3'd3;
    localparam logic [2:0] S_FLASH  = 3'd4;

    // Counter reload values: a state lasts C_INT_x blinks, the last one being expiry.
    localparam logic [C_CNT_W-1:0] LD_GREEN  = C_CNT_W'(C_INT_GREEN - 1);
    localparam logic [C_CNT_W-1:0] LD_YELLOW = C_CNT_W'(C_INT_YELLOW - 1);
    localparam logic [C_CNT_W-1:0] LD_CLEAR  = C_CNT_W'(C_INT_CLEAR - 1);
    localparam logic [C_CNT_W-1:0] LD_WALK   = C_CNT_W'(C_INT_WALK - 1);
    localparam logic [AW-1:0]      LAST_WAY  = AW'(C_N_WAYS - 1);

    logic [2:0]            state_q, state_d;
    logic [C_CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]         way_q, way_d;
    logic                  pend_walk_q, pend_walk_d;
    logic                  phase_q, phase_d;
    logic [C_N_WAYS-1:0]   ped_q, ped_d;
    logic [2*C_N_WAYS-1:0] light_q, light_d;
    logic [AW-1:0]         next_way;

    // Next approach to serve: first way after the current one with demand,
    // otherwise plain round-robin so no approach starves.
    always_comb begin
        logic [AW-1:0] idx;
        logic          found;
        next_way = (way_q == LAST_WAY) ? '0 : way_q + 1'b1;
        found    = 1'b0;
        idx      = way_q;
        for (int k = 1; k < C_N_WAYS; k++) begin
            idx = (idx == LAST_WAY) ? '0 : idx + 1'b1;
            if (!found && inTraffic[idx]) begin
                found    = 1'b1;
                next_way = idx;
            end
        end
    end

    // Phase sequencing, interval counting and pedestrian latching.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        way_d       = way_q;
        pend_walk_d = pend_walk_q;
        phase_d     = phase_q;
        case (state_q)
            S_WALK:  ped_d = ped_q;
            S_FLASH: ped_d = '0;
            default: ped_d = ped_q | inPedestrian;
        endcase

        if (state_q == S_FLASH) begin
            if (blink) begin
                if (!inMode) begin
                    state_d = S_CLEAR;
                    cnt_d   = LD_CLEAR;
                    way_d   = LAST_WAY;
                end else begin
                    phase_d = ~phase_q;
                end
            end
        end else if (blink) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (state_q)
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        cnt_d   = LD_YELLOW;
                    end
                    S_YELLOW: begin
                        state_d = S_CLEAR;
                        cnt_d   = LD_CLEAR;
                    end
                    S_WALK: begin
                        // A press in this very cycle is dropped: the clear wins.
                        state_d     = S_CLEAR;
                        cnt_d       = LD_CLEAR;
                        pend_walk_d = 1'b1;
                        ped_d       = '0;
                    end
                    default: begin
                        // CLEAR expiry decides on the latches as they were, not
                        // including a press arriving in this same cycle.
                        pend_walk_d = 1'b0;
                        if (inMode) begin
                            state_d = S_FLASH;
                            phase_d = 1'b0;
                            ped_d   = '0;
                        end else if (pend_walk_q || ped_q == '0) begin
                            state_d = S_GREEN;
                            cnt_d   = LD_GREEN;
                            way_d   = next_way;
                        end else begin
                            state_d = S_WALK;
                            cnt_d   = LD_WALK;
                        end
                    end
                endcase
            end
        end
    end

    // Per-approach light code derived from the upcoming state so outputs are registered.
    generate
        for (genvar gi = 0; gi < C_N_WAYS; gi++) begin : g_light
            assign light_d[2*gi +: 2] =
                (state_d == S_GREEN  && way_d == AW'(gi)) ? 2'd1 :
                (state_d == S_YELLOW && way_d == AW'(gi)) ? 2'd2 :
                (state_d == S_WALK   && ped_d[gi])        ? 2'd3 :
                (state_d == S_FLASH  && phase_d)          ? 2'd2 : 2'd0;
        end
    endgenerate

    // State registers with synchronous active-low reset to all-red clearance.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= S_CLEAR;
            cnt_q       <= LD_CLEAR;
            way_q       <= LAST_WAY;
            pend_walk_q <= 1'b0;
            phase_q     <= 1'b0;
            ped_q       <= '0;
            light_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            way_q       <= way_d;
            pend_walk_q <= pend_walk_d;
            phase_q     <= phase_d;
            ped_q       <= ped_d;
            light_q     <= light_d;
        end
    end

    assign outLight    = light_q;
    assign outPedLatch = ped_q;
    assign outActive   = way_q;

endmodule
